// File: rtl/ah_rr_grant_mux.sv
// ah_rr_grant_mux: round-robin grant to payload mux with 2-entry output queue and ack/nack (macro AH_GRANT_MUX_ONEHOT_CHECK_EN)
module ah_rr_grant_mux #(
  parameter int N  = 12,
  parameter int DW = 32,
  parameter int IW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    grant,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ack,
  output logic [N-1:0]    req_nack,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [IW-1:0]   out_id,
  input  logic            out_ready,
  output logic            overflow,
  output logic            err_multi
);
  logic [IW-1:0] idx;
  logic [DW-1:0] sel;
  logic [N-1:0]  oh;
  logic          gv, pop, full, push, drop;
  logic [DW-1:0] data_q [2];
  logic [IW-1:0] id_q [2];
  logic          wr_q, wr_d, rd_q, rd_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [N-1:0]  ack_q, ack_d, nack_q, nack_d;
  logic          ovf_q;
  // Encode the lowest set grant bit into index, one-hot and payload
  always_comb begin
    idx = '0;
    sel = '0;
    oh  = '0;
    for (int i = N - 1; i >= 0; i--)
      if (grant[i]) begin
        idx   = IW'(i);
        sel   = req_data[i*DW +: DW];
        oh    = '0;
        oh[i] = 1'b1;
      end
  end
`ifdef AH_GRANT_MUX_ONEHOT_CHECK_EN
  logic multi, err_q;
  assign multi     = |(grant & (grant - {{(N-1){1'b0}}, 1'b1}));
  assign gv        = |grant & !multi;
  assign err_multi = err_q;
  // Sticky flag for a grant with more than one bit set
  always_ff @(posedge clk or posedge rst)
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | multi;
`else
  assign gv        = |grant;
  assign err_multi = 1'b0;
`endif
  assign pop       = (cnt_q != 2'd0) & out_ready;
  assign full      = cnt_q == 2'd2;
  assign push      = gv & (!full | pop);
  assign drop      = gv & full & !pop;
  assign out_valid = cnt_q != 2'd0;
  assign out_data  = data_q[rd_q];
  assign out_id    = id_q[rd_q];
  assign req_ack   = ack_q;
  assign req_nack  = nack_q;
  assign overflow  = ovf_q;
  // Queue pointer/count and handshake pulse next-state
  always_comb begin
    wr_d   = push ? ~wr_q : wr_q;
    rd_d   = pop ? ~rd_q : rd_q;
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
    ack_d  = push ? oh : '0;
    nack_d = drop ? oh : '0;
  end
  // Queue storage, pointers, pulses and sticky overflow
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      id_q[0]   <= '0;
      id_q[1]   <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      cnt_q     <= 2'd0;
      ack_q     <= '0;
      nack_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (push) begin
        data_q[wr_q] <= sel;
        id_q[wr_q]   <= idx;
      end
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      ack_q  <= ack_d;
      nack_q <= nack_d;
      ovf_q  <= ovf_q | drop;
    end
endmodule

// File: tb/tb_ah_rr_grant_mux.sv
// tb_ah_rr_grant_mux: directed checks of capture, drop, queue order, reset and multi-bit grants
module tb_ah_rr_grant_mux;
  localparam int N = 12, DW = 32, IW = 4;
  logic            clk = 1'b0, rst = 1'b1, out_ready = 1'b0;
  logic [N-1:0]    grant = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ack, req_nack;
  logic            out_valid, overflow, err_multi;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_id;
  int errs = 0, chks = 0;

  ah_rr_grant_mux #(.N(N), .DW(DW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .grant(grant), .req_data(req_data),
    .req_ack(req_ack), .req_nack(req_nack), .out_valid(out_valid),
    .out_data(out_data), .out_id(out_id), .out_ready(out_ready),
    .overflow(overflow), .err_multi(err_multi)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    chks++; if ({out_valid, req_ack, req_nack, overflow, err_multi} !== '0) begin errs++; $display("FAIL reset_ctrl got=%b exp=0", {out_valid, req_ack, req_nack, overflow, err_multi}); end
    chks++; if ({out_data, out_id} !== '0) begin errs++; $display("FAIL reset_data got=%h exp=0", {out_data, out_id}); end
    rst = 1'b0;
  endtask

  task automatic test_capture();
    out_ready = 1'b1;
    req_data[2*DW +: DW] = 32'hA5A5_0002;
    grant = 12'h004;
    step();
    grant = '0;
    chks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL cap_valid got=%b exp=1", out_valid); end
    chks++; if (out_id !== 4'd2) begin errs++; $display("FAIL cap_id got=%0d exp=2", out_id); end
    chks++; if (out_data !== 32'hA5A5_0002) begin errs++; $display("FAIL cap_data got=%h exp=a5a50002", out_data); end
    chks++; if (req_ack !== 12'h004) begin errs++; $display("FAIL cap_ack got=%h exp=004", req_ack); end
    step();
    chks++; if ({out_valid, req_ack, req_nack} !== '0) begin errs++; $display("FAIL idle got=%b exp=0", {out_valid, req_ack, req_nack}); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    req_data[0*DW +: DW]  = 32'hD000_0000;
    req_data[11*DW +: DW] = 32'hD000_000B;
    req_data[4*DW +: DW]  = 32'hD000_0004;
    grant = 12'h001;
    step();
    chks++; if (req_ack !== 12'h001 || out_id !== 4'd0) begin errs++; $display("FAIL ovf_g0 got=%h/%0d exp=001/0", req_ack, out_id); end
    grant = 12'h800;
    step();
    chks++; if (req_ack !== 12'h800 || out_id !== 4'd0) begin errs++; $display("FAIL ovf_g11 got=%h/%0d exp=800/0", req_ack, out_id); end
    grant = 12'h010;
    step();
    grant = '0;
    chks++; if (req_nack !== 12'h010 || req_ack !== '0) begin errs++; $display("FAIL ovf_nack got=%h/%h exp=010/000", req_nack, req_ack); end
    chks++; if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    chks++; if (out_id !== 4'd0 || out_data !== 32'hD000_0000) begin errs++; $display("FAIL ovf_hold got=%0d/%h exp=0/d0000000", out_id, out_data); end
    step();
    chks++; if (req_nack !== '0 || out_id !== 4'd0) begin errs++; $display("FAIL ovf_stall got=%h/%0d exp=000/0", req_nack, out_id); end
  endtask

  task automatic test_push_pop_full();
    out_ready = 1'b1;
    req_data[5*DW +: DW] = 32'hD000_0005;
    grant = 12'h020;
    step();
    grant = '0;
    chks++; if (req_ack !== 12'h020 || req_nack !== '0) begin errs++; $display("FAIL pp_ack got=%h/%h exp=020/000", req_ack, req_nack); end
    chks++; if (out_valid !== 1'b1 || out_id !== 4'd11 || out_data !== 32'hD000_000B) begin errs++; $display("FAIL pp_head got=%b/%0d/%h exp=1/11/d000000b", out_valid, out_id, out_data); end
  endtask

  task automatic test_drain();
    step();
    chks++; if (out_valid !== 1'b1 || out_id !== 4'd5 || out_data !== 32'hD000_0005) begin errs++; $display("FAIL drain_2nd got=%b/%0d/%h exp=1/5/d0000005", out_valid, out_id, out_data); end
    step();
    chks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
    chks++; if (overflow !== 1'b1) begin errs++; $display("FAIL drain_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    grant = 12'h001;
    step();
    req_data[1*DW +: DW] = 32'hD000_0001;
    grant = 12'h002;
    step();
    grant = '0;
    chks++; if (req_ack !== 12'h002) begin errs++; $display("FAIL rm_pending got=%h exp=002", req_ack); end
    rst = 1'b1;
    step();
    chks++; if ({out_valid, req_ack, req_nack, overflow} !== '0) begin errs++; $display("FAIL rm_clear got=%b exp=0", {out_valid, req_ack, req_nack, overflow}); end
    rst = 1'b0;
    req_data[2*DW +: DW] = 32'hB0B0_0002;
    grant = 12'h004;
    step();
    grant = '0;
    chks++; if (out_valid !== 1'b1 || out_id !== 4'd2 || req_ack !== 12'h004 || out_data !== 32'hB0B0_0002) begin errs++; $display("FAIL rm_after got=%b/%0d/%h/%h exp=1/2/004/b0b00002", out_valid, out_id, req_ack, out_data); end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_multi();
    out_ready = 1'b0;
    req_data[0*DW +: DW] = 32'hC000_0000;
    req_data[1*DW +: DW] = 32'hC000_0001;
    grant = 12'h003;
    step();
    grant = '0;
`ifdef AH_GRANT_MUX_ONEHOT_CHECK_EN
    chks++; if (err_multi !== 1'b1) begin errs++; $display("FAIL multi_err got=%b exp=1", err_multi); end
    chks++; if ({out_valid, req_ack, req_nack} !== '0) begin errs++; $display("FAIL multi_none got=%b exp=0", {out_valid, req_ack, req_nack}); end
`else
    chks++; if (err_multi !== 1'b0) begin errs++; $display("FAIL multi_err got=%b exp=0", err_multi); end
    chks++; if (out_valid !== 1'b1 || out_id !== 4'd0 || req_ack !== 12'h001 || out_data !== 32'hC000_0000) begin errs++; $display("FAIL multi_low got=%b/%0d/%h/%h exp=1/0/001/c0000000", out_valid, out_id, req_ack, out_data); end
`endif
  endtask

  initial begin
    test_reset();
    test_capture();
    test_overflow();
    test_push_pop_full();
    test_drain();
    test_reset_mid();
    test_multi();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
